// File: rtl/jam_cost_server.sv
// jam_cost_server: cost-table responder for the job-assignment engine.
// Loads a 64-entry worker x job cost table and holds the engine in reset
// until the table is complete. It then serves combinational cost lookups
// and captures the engine's final result together with a run-length cycle count.
// Optional feature macro: JAM_QUERY_STATS_EN adds the PermCnt assignment counter.
module jam_cost_server #(
  parameter int unsigned COST_W = 7,
  parameter int unsigned CNT_W  = 24
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LdValid,
  input  logic [COST_W-1:0] LdData,
  output logic              LdReady,
  output logic              JamRst,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  input  logic              Restart,
  output logic              Done,
  output logic [9:0]        ResMinCost,
  output logic [3:0]        ResMatchCount,
`ifdef JAM_QUERY_STATS_EN
  output logic [15:0]       PermCnt,
`endif
  output logic [CNT_W-1:0]  CycleCnt
);

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  typedef enum logic [1:0] {LOAD, RELEASE, SERVE, DONE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic                rel_cnt, rel_cnt_d;
  logic                ld_ready_d, jam_rst_d, done_d;
  logic [9:0]          res_min_d;
  logic [3:0]          res_cnt_d;
  logic [CNT_W-1:0]    cyc_d;
  logic                xfer_c;
  logic [COST_W-1:0]   table_q [DEPTH];

`ifdef JAM_QUERY_STATS_EN
  logic [15:0]         perm_d;
  logic                w7_q;
`endif

  assign xfer_c = (state == LOAD) && LdValid && LdReady;

  // Lookup is a pure combinational read of the table.
  assign Cost = table_q[{W, J}];

  // Table storage: written by accepted load entries, never reset.
  always_ff @(posedge CLK) begin
    if (RST_N && xfer_c) table_q[addr] <= LdData;
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= LOAD;
      addr          <= '0;
      rel_cnt       <= 1'b0;
      LdReady       <= 1'b0;
      JamRst        <= 1'b1;
      Done          <= 1'b0;
      ResMinCost    <= '0;
      ResMatchCount <= '0;
      CycleCnt      <= '0;
`ifdef JAM_QUERY_STATS_EN
      PermCnt       <= '0;
      w7_q          <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      addr          <= addr_d;
      rel_cnt       <= rel_cnt_d;
      LdReady       <= ld_ready_d;
      JamRst        <= jam_rst_d;
      Done          <= done_d;
      ResMinCost    <= res_min_d;
      ResMatchCount <= res_cnt_d;
      CycleCnt      <= cyc_d;
`ifdef JAM_QUERY_STATS_EN
      PermCnt       <= perm_d;
      w7_q          <= (W == 3'd7);
`endif
    end
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d    = state;
    addr_d     = addr;
    rel_cnt_d  = rel_cnt;
    ld_ready_d = LdReady;
    jam_rst_d  = JamRst;
    done_d     = Done;
    res_min_d  = ResMinCost;
    res_cnt_d  = ResMatchCount;
    cyc_d      = CycleCnt;
`ifdef JAM_QUERY_STATS_EN
    perm_d     = PermCnt;
`endif
    case (state)
      LOAD: begin
        ld_ready_d = 1'b1;
        if (xfer_c) begin
          addr_d = addr + ADDR_W'(1);
          if (addr == ADDR_W'(DEPTH - 1)) begin
            ld_ready_d = 1'b0;
            state_d    = RELEASE;
          end
        end
      end
      RELEASE: begin
        // Two cycles of engine reset flush its registered Valid.
        jam_rst_d = 1'b1;
        if (rel_cnt) begin
          rel_cnt_d = 1'b0;
          jam_rst_d = 1'b0;
          state_d   = SERVE;
        end else begin
          rel_cnt_d = 1'b1;
        end
      end
      SERVE: begin
`ifdef JAM_QUERY_STATS_EN
        if ((W == 3'd7) && !w7_q && (PermCnt != 16'hFFFF))
          perm_d = PermCnt + 16'd1;
`endif
        if (Valid) begin
          res_min_d = MinCost;
          res_cnt_d = MatchCount;
          done_d    = 1'b1;
          state_d   = DONE;
        end else if (CycleCnt != {CNT_W{1'b1}}) begin
          cyc_d = CycleCnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (Restart) begin
          done_d    = 1'b0;
          cyc_d     = '0;
          jam_rst_d = 1'b1;
          rel_cnt_d = 1'b0;
          state_d   = RELEASE;
`ifdef JAM_QUERY_STATS_EN
          perm_d    = '0;
`endif
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule
